// File: rtl/coeff_token_vlc1_decoder.sv
// Bit-serial CAVLC coeff_token decoder for VLC table 1 (2 <= nC < 4).
// Accepts one bit per bitValid/bitReady handshake, matches the growing
// prefix against the 62-entry code table, and presents TotalCoeff and
// TrailingOnes on a valid/ready result port.
module coeff_token_vlc1_decoder #(
    parameter int MAXLEN = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bitIn,
    input  logic       bitValid,
    output logic       bitReady,
    output logic       tokenValid,
    input  logic       tokenReady,
    output logic [4:0] totalCoeff,
    output logic [1:0] trailingOnes,
    output logic [3:0] codeLen,
    output logic       codeErr,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t      state, state_nx;
    logic [12:0] shreg;
    logic [3:0]  cnt;
    logic [13:0] cand;
    logic [3:0]  cand_len;
    logic [7:0]  hit;
    logic        accept;
    logic        last_bit;

    // Packs a table hit as {hit, trailing_ones, total_coeff}.
    function automatic logic [7:0] ent(input logic [1:0] t1, input logic [4:0] tc);
        return {1'b1, t1, tc};
    endfunction

    // Code table lookup: key is {length, right-aligned codeword value}.
    function automatic logic [7:0] lookup(input logic [3:0] len, input logic [13:0] w);
        logic [7:0] r;
        r = '0;
        case ({len, w})
            {4'd2,  14'd3}:  r = ent(2'd0, 5'd0);
            {4'd6,  14'd11}: r = ent(2'd0, 5'd1);
            {4'd2,  14'd2}:  r = ent(2'd1, 5'd1);
            {4'd6,  14'd7}:  r = ent(2'd0, 5'd2);
            {4'd5,  14'd7}:  r = ent(2'd1, 5'd2);
            {4'd3,  14'd3}:  r = ent(2'd2, 5'd2);
            {4'd7,  14'd7}:  r = ent(2'd0, 5'd3);
            {4'd6,  14'd10}: r = ent(2'd1, 5'd3);
            {4'd6,  14'd9}:  r = ent(2'd2, 5'd3);
            {4'd4,  14'd5}:  r = ent(2'd3, 5'd3);
            {4'd8,  14'd7}:  r = ent(2'd0, 5'd4);
            {4'd6,  14'd6}:  r = ent(2'd1, 5'd4);
            {4'd6,  14'd5}:  r = ent(2'd2, 5'd4);
            {4'd4,  14'd4}:  r = ent(2'd3, 5'd4);
            {4'd8,  14'd4}:  r = ent(2'd0, 5'd5);
            {4'd7,  14'd6}:  r = ent(2'd1, 5'd5);
            {4'd7,  14'd5}:  r = ent(2'd2, 5'd5);
            {4'd5,  14'd6}:  r = ent(2'd3, 5'd5);
            {4'd9,  14'd7}:  r = ent(2'd0, 5'd6);
            {4'd8,  14'd6}:  r = ent(2'd1, 5'd6);
            {4'd8,  14'd5}:  r = ent(2'd2, 5'd6);
            {4'd6,  14'd8}:  r = ent(2'd3, 5'd6);
            {4'd11, 14'd15}: r = ent(2'd0, 5'd7);
            {4'd9,  14'd6}:  r = ent(2'd1, 5'd7);
            {4'd9,  14'd5}:  r = ent(2'd2, 5'd7);
            {4'd6,  14'd4}:  r = ent(2'd3, 5'd7);
            {4'd11, 14'd11}: r = ent(2'd0, 5'd8);
            {4'd11, 14'd14}: r = ent(2'd1, 5'd8);
            {4'd11, 14'd13}: r = ent(2'd2, 5'd8);
            {4'd7,  14'd4}:  r = ent(2'd3, 5'd8);
            {4'd12, 14'd15}: r = ent(2'd0, 5'd9);
            {4'd11, 14'd10}: r = ent(2'd1, 5'd9);
            {4'd11, 14'd9}:  r = ent(2'd2, 5'd9);
            {4'd9,  14'd4}:  r = ent(2'd3, 5'd9);
            {4'd12, 14'd11}: r = ent(2'd0, 5'd10);
            {4'd12, 14'd14}: r = ent(2'd1, 5'd10);
            {4'd12, 14'd13}: r = ent(2'd2, 5'd10);
            {4'd11, 14'd12}: r = ent(2'd3, 5'd10);
            {4'd12, 14'd8}:  r = ent(2'd0, 5'd11);
            {4'd12, 14'd10}: r = ent(2'd1, 5'd11);
            {4'd12, 14'd9}:  r = ent(2'd2, 5'd11);
            {4'd11, 14'd8}:  r = ent(2'd3, 5'd11);
            {4'd13, 14'd15}: r = ent(2'd0, 5'd12);
            {4'd13, 14'd14}: r = ent(2'd1, 5'd12);
            {4'd13, 14'd13}: r = ent(2'd2, 5'd12);
            {4'd12, 14'd12}: r = ent(2'd3, 5'd12);
            {4'd13, 14'd11}: r = ent(2'd0, 5'd13);
            {4'd13, 14'd10}: r = ent(2'd1, 5'd13);
            {4'd13, 14'd9}:  r = ent(2'd2, 5'd13);
            {4'd13, 14'd12}: r = ent(2'd3, 5'd13);
            {4'd13, 14'd7}:  r = ent(2'd0, 5'd14);
            {4'd14, 14'd11}: r = ent(2'd1, 5'd14);
            {4'd13, 14'd6}:  r = ent(2'd2, 5'd14);
            {4'd13, 14'd8}:  r = ent(2'd3, 5'd14);
            {4'd14, 14'd9}:  r = ent(2'd0, 5'd15);
            {4'd14, 14'd8}:  r = ent(2'd1, 5'd15);
            {4'd14, 14'd10}: r = ent(2'd2, 5'd15);
            {4'd13, 14'd1}:  r = ent(2'd3, 5'd15);
            {4'd14, 14'd7}:  r = ent(2'd0, 5'd16);
            {4'd14, 14'd6}:  r = ent(2'd1, 5'd16);
            {4'd14, 14'd5}:  r = ent(2'd2, 5'd16);
            {4'd14, 14'd4}:  r = ent(2'd3, 5'd16);
            default:         r = '0;
        endcase
        return r;
    endfunction

    // Candidate codeword: bits already held plus the bit being offered now.
    assign cand     = {shreg, bitIn};
    assign cand_len = cnt + 4'd1;
    assign hit      = lookup(cand_len, cand);
    assign accept   = (state == ACCUM) && bitValid;
    assign last_bit = (cand_len == 4'(MAXLEN));

    // State register; reset discards any decode in progress.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs; the final bit moves us out of ACCUM
    // on the same edge so bitReady drops before a look-ahead bit is taken.
    always_comb begin
        state_nx   = state;
        bitReady   = 1'b0;
        tokenValid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nx = ACCUM;
            end
            ACCUM: begin
                bitReady = 1'b1;
                if (accept && (hit[7] || last_bit)) state_nx = OUT;
            end
            OUT: begin
                tokenValid = 1'b1;
                if (tokenReady) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shift register, bit count and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            cnt          <= '0;
            totalCoeff   <= '0;
            trailingOnes <= '0;
            codeLen      <= '0;
            codeErr      <= 1'b0;
        end else if (state == IDLE && start) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            if (hit[7]) begin
                totalCoeff   <= hit[4:0];
                trailingOnes <= hit[6:5];
                codeLen      <= cand_len;
                codeErr      <= 1'b0;
            end else if (last_bit) begin
                totalCoeff   <= '0;
                trailingOnes <= '0;
                codeLen      <= cand_len;
                codeErr      <= 1'b1;
            end else begin
                shreg <= {shreg[11:0], bitIn};
                cnt   <= cand_len;
            end
        end
    end

endmodule
